// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: sequential instruction prefetch into a small FIFO.
// One fetch outstanding at a time; a redirect flushes the queue and refetches.
module fetch_prefetch_buffer #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   input  logic                  instr_ready_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {S_RUN, S_DROP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_drop_addr;
   logic [ADDR_WIDTH-1:0] r_pc_q   [DEPTH];
   logic [DATA_WIDTH-1:0] r_data_q [DEPTH];
   logic [PW-1:0]         r_rd;
   logic [PW-1:0]         r_wr;
   logic [CW-1:0]         r_count;
   logic                  w_full;
   logic                  w_done;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_redir_pc;

   assign w_full     = (r_count == CW'(DEPTH));
   assign w_done     = mem_req_o & mem_rvalid_i;
   assign w_push     = (r_state == S_RUN) & w_done & ~redirect_i;
   assign w_pop      = instr_valid_o & instr_ready_i;
   assign w_redir_pc = redirect_pc_i & ~ADDR_WIDTH'(3);

   assign instr_valid_o = (r_count != '0);
   assign instr_o       = r_data_q[r_rd];
   assign instr_pc_o    = r_pc_q[r_rd];

   // Next state and memory request; DROP replays the abandoned address.
   always_comb begin
      w_state_nxt = r_state;
      mem_req_o   = 1'b0;
      mem_addr_o  = r_fetch_pc;
      unique case (r_state)
         S_RUN: begin
            mem_req_o = ~rst & ~w_full;
            if (redirect_i && mem_req_o && !mem_rvalid_i)
               w_state_nxt = S_DROP;
         end
         S_DROP: begin
            mem_req_o  = ~rst;
            mem_addr_o = r_drop_addr;
            if (mem_rvalid_i)
               w_state_nxt = S_RUN;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_RUN;
      else
         r_state <= w_state_nxt;
   end

   // Capture the in-flight address when a redirect abandons it.
   always_ff @(posedge clk) begin
      if (rst)
         r_drop_addr <= '0;
      else if (r_state == S_RUN && w_state_nxt == S_DROP)
         r_drop_addr <= r_fetch_pc;
   end

   // Fetch PC, pointers and occupancy; redirect overrides push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
      end else if (redirect_i) begin
         r_fetch_pc <= w_redir_pc;
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_wr       <= r_wr + PW'(1);
            r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
         end
         if (w_pop)
            r_rd <= r_rd + PW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   // FIFO storage write of {pc, instruction}.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_q[r_wr]   <= r_fetch_pc;
         r_data_q[r_wr] <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed vectors against a wait-state memory
// that returns word = address.
module tb_fetch_prefetch_buffer;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [9:0]  instr_pc;
   logic        ready;
   logic        redirect;
   logic [9:0]  redirect_pc;

   int total;
   int bad;
   int waits;
   int wcnt;

   fetch_prefetch_buffer #(
      .ADDR_WIDTH(10),
      .DATA_WIDTH(32),
      .DEPTH(4),
      .RESET_PC(10'h000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_req_o(mem_req),
      .mem_addr_o(mem_addr),
      .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata),
      .instr_valid_o(instr_valid),
      .instr_o(instr),
      .instr_pc_o(instr_pc),
      .instr_ready_i(ready),
      .redirect_i(redirect),
      .redirect_pc_i(redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: responds after `waits` stall cycles of a held request.
   always @(posedge clk) begin
      if (!mem_req || mem_rvalid)
         wcnt <= 0;
      else
         wcnt <= wcnt + 1;
   end

   always_comb begin
      mem_rvalid = mem_req && (wcnt >= waits);
      mem_rdata  = {22'h0, mem_addr};
   end

   typedef struct {
      logic       rdy;
      logic       rd;
      logic [9:0] rpc;
      logic       req;
      logic [9:0] addr;
      logic       vld;
      logic [9:0] pc;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rdy, input logic rd,
                      input logic [9:0] rpc, input logic req,
                      input logic [9:0] addr, input logic vld,
                      input logic [9:0] pc);
      vec_t v;
      v.rdy = rdy; v.rd = rd; v.rpc = rpc;
      v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_reset(input int w);
      rst      = 1'b1;
      redirect = 1'b0;
      ready    = 1'b0;
      waits    = w;
      @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'h0, mem_req}, 32'h0);
      chk("rst_vld", {31'h0, instr_valid}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      total       = 0;
      bad         = 0;
      waits       = 0;
      redirect_pc = '0;

      // Rows: rdy, redirect, rpc | req, addr, valid, head pc
      add(0, 0, 10'h000, 1, 10'h000, 0, 10'h000);
      add(0, 0, 10'h000, 1, 10'h004, 1, 10'h000);
      add(0, 0, 10'h000, 1, 10'h008, 1, 10'h000);
      add(0, 0, 10'h000, 1, 10'h00C, 1, 10'h000);
      add(0, 0, 10'h000, 0, 10'h010, 1, 10'h000);
      add(1, 0, 10'h000, 0, 10'h010, 1, 10'h000);
      add(0, 0, 10'h000, 1, 10'h010, 1, 10'h004);
      add(1, 0, 10'h000, 0, 10'h014, 1, 10'h004);
      add(1, 0, 10'h000, 1, 10'h014, 1, 10'h008);
      add(1, 0, 10'h000, 1, 10'h018, 1, 10'h00C);
      add(1, 0, 10'h000, 1, 10'h01C, 1, 10'h010);
      add(0, 1, 10'h100, 1, 10'h020, 1, 10'h014);
      add(0, 0, 10'h000, 1, 10'h100, 0, 10'h000);
      add(1, 0, 10'h000, 1, 10'h104, 1, 10'h100);
      add(1, 1, 10'h103, 1, 10'h108, 1, 10'h104);
      add(1, 0, 10'h000, 1, 10'h100, 0, 10'h000);
      add(1, 1, 10'h3F8, 1, 10'h104, 1, 10'h100);
      add(1, 0, 10'h000, 1, 10'h3F8, 0, 10'h000);
      add(1, 0, 10'h000, 1, 10'h3FC, 1, 10'h3F8);
      add(1, 0, 10'h000, 1, 10'h000, 1, 10'h3FC);
      add(1, 0, 10'h000, 1, 10'h004, 1, 10'h000);

      do_reset(0);
      for (int i = 0; i < vq.size(); i++) begin
         ready       = vq[i].rdy;
         redirect    = vq[i].rd;
         redirect_pc = vq[i].rpc;
         @(negedge clk);
         chk($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, vq[i].req});
         chk($sformatf("v%0d_addr", i), {22'h0, mem_addr}, {22'h0, vq[i].addr});
         chk($sformatf("v%0d_vld", i), {31'h0, instr_valid}, {31'h0, vq[i].vld});
         if (vq[i].vld) begin
            chk($sformatf("v%0d_pc", i), {22'h0, instr_pc}, {22'h0, vq[i].pc});
            chk($sformatf("v%0d_ins", i), instr, {22'h0, vq[i].pc});
         end
         @(posedge clk);
         #1;
      end
      redirect = 1'b0;
      ready    = 1'b0;

      // Redirect during a stalled fetch at 0x20 with 3 wait states.
      do_reset(3);
      ready = 1'b1;
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 10'h020) found = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("b_find20", {31'h0, found}, 32'h1);
      if (found) begin
         chk("b_rv0", {31'h0, mem_rvalid}, 32'h0);
         redirect    = 1'b1;
         redirect_pc = 10'h080;
         @(posedge clk);
         #1 redirect = 1'b0;
         for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("b_d%0d_req", i), {31'h0, mem_req}, 32'h1);
            chk($sformatf("b_d%0d_addr", i), {22'h0, mem_addr}, 32'h020);
            chk($sformatf("b_d%0d_vld", i), {31'h0, instr_valid}, 32'h0);
            chk($sformatf("b_d%0d_rv", i), {31'h0, mem_rvalid},
                (i == 3) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
         end
         @(negedge clk);
         chk("b_new_req", {31'h0, mem_req}, 32'h1);
         chk("b_new_addr", {22'h0, mem_addr}, 32'h080);
         found = 0;
         for (int i = 0; i < 12 && !found; i++) begin
            if (instr_valid) found = 1;
            else @(negedge clk);
         end
         chk("b_got_vld", {31'h0, found}, 32'h1);
         chk("b_first_pc", {22'h0, instr_pc}, 32'h080);
         chk("b_first_ins", instr, 32'h080);
      end

      // Reset while the FIFO holds entries and a fetch is outstanding.
      @(posedge clk);
      #1;
      do_reset(0);
      repeat (5) @(posedge clk);
      #1 waits = 3;
      @(negedge clk);
      chk("c_full_req", {31'h0, mem_req}, 32'h0);
      chk("c_full_vld", {31'h0, instr_valid}, 32'h1);
      ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      @(negedge clk);
      chk("c_re_req", {31'h0, mem_req}, 32'h1);
      chk("c_re_addr", {22'h0, mem_addr}, 32'h010);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("c_rst_req", {31'h0, mem_req}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("c_post_vld", {31'h0, instr_valid}, 32'h0);
      chk("c_post_req", {31'h0, mem_req}, 32'h1);
      chk("c_post_addr", {22'h0, mem_addr}, 32'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
